input_packer: RTL and testbench



---
 rtl/input_packer.sv | 104 ++++++++++
 tb/tb_input_packer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_packer.sv
// Stream width upsizer: packs RATIO consecutive input words into one registered
// wide output word and flags every cfg_length-th output word with out_last.
module input_packer #(
  parameter int DATA_WIDTH   = 32,
  parameter int RATIO        = 4,
  parameter int LENGTH_WIDTH = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [LENGTH_WIDTH-1:0]       cfg_length,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [RATIO*DATA_WIDTH-1:0]   out_data,
  output logic                          out_valid,
  output logic                          out_last,
  input  logic                          out_ready
);

  localparam int SLOT_W = $clog2(RATIO);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(RATIO - 1);

  logic [SLOT_W-1:0]                  r_slot;
  logic [RATIO-2:0][DATA_WIDTH-1:0]   r_acc;
  logic [LENGTH_WIDTH-1:0]            r_pkt;
  logic [RATIO*DATA_WIDTH-1:0]        r_out_data;
  logic                               r_out_valid;
  logic                               r_out_last;

  logic w_last_slot;
  logic w_in_ready;
  logic w_accept;
  logic w_load;
  logic w_pkt_last;
  logic w_len_zero;

  // Only a completing word can collide with an unconsumed output word.
  assign w_last_slot = (r_slot == LAST_SLOT);
  assign w_in_ready  = ~w_last_slot | ~r_out_valid | out_ready;
  assign w_accept    = in_valid & w_in_ready;
  assign w_load      = w_accept & w_last_slot;
  assign w_len_zero  = (cfg_length == {LENGTH_WIDTH{1'b0}});
  assign w_pkt_last  = ~w_len_zero & (r_pkt >= (cfg_length - LENGTH_WIDTH'(1)));

  // Lane pointer for the next accepted input word.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_slot <= {SLOT_W{1'b0}};
    end else if (w_accept) begin
      if (w_last_slot) begin
        r_slot <= {SLOT_W{1'b0}};
      end else begin
        r_slot <= r_slot + SLOT_W'(1);
      end
    end
  end

  // Lanes 0..RATIO-2 hold the partial group; the top lane comes straight from in_data.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_acc <= '{default: {DATA_WIDTH{1'b0}}};
    end else begin
      for (int i = 0; i < RATIO - 1; i++) begin
        if (w_accept && (r_slot == SLOT_W'(i))) begin
          r_acc[i] <= in_data;
        end
      end
    end
  end

  // Output stage: a load always wins over a concurrent handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_out_data  <= {(RATIO*DATA_WIDTH){1'b0}};
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= {in_data, r_acc};
      r_out_valid <= 1'b1;
      r_out_last  <= w_pkt_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Packet position, sampled against the live cfg_length on every load.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_pkt <= {LENGTH_WIDTH{1'b0}};
    end else if (w_load) begin
      if (w_len_zero || w_pkt_last) begin
        r_pkt <= {LENGTH_WIDTH{1'b0}};
      end else begin
        r_pkt <= r_pkt + LENGTH_WIDTH'(1);
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_input_packer.sv
// Self-checking bench for input_packer (RATIO=4, DATA_WIDTH=32): directed vector
// table, hand-written corner sequences and a scoreboarded random soak.
module tb_input_packer;

  localparam int DW = 32;
  localparam int R  = 4;
  localparam int LW = 16;
  localparam int OW = DW * R;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [LW-1:0] cfg_length = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready = 1'b0;

  always #5 aclk = ~aclk;

  input_packer #(.DATA_WIDTH(DW), .RATIO(R), .LENGTH_WIDTH(LW)) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_length(cfg_length),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  // Reference model state
  logic [DW-1:0] m_lane [R];
  int            m_slot = 0;
  int            m_pkt = 0;
  logic [OW-1:0] q_data [$];
  logic          q_last [$];
  int            accepted = 0;
  int            sec_outs = 0;
  logic [31:0]   sec_last_mask = '0;
  logic [OW-1:0] last_taken_data = '0;
  logic          last_taken_last = 1'b0;
  logic          last_in_ready = 1'b1;
  logic          last_accept = 1'b0;
  logic          prev_hold = 1'b0;
  logic [OW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  logic [LW-1:0] cfg_drv = '0;
  logic [DW-1:0] word_ctr = 32'h1000_0000;

  task automatic model_reset();
    m_slot = 0;
    m_pkt = 0;
    q_data.delete();
    q_last.delete();
    prev_hold = 1'b0;
  endtask

  task automatic sec_reset();
    sec_outs = 0;
    sec_last_mask = '0;
  endtask

  // One cycle: drive at negedge, check and update the model 1 time unit later.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    logic [OW-1:0] pk;
    logic          lst;
    logic          exp_rdy;
    @(negedge aclk);
    in_valid = v;
    in_data = d;
    out_ready = r;
    cfg_length = cfg_drv;
    #1;
    if (prev_hold) begin
      chk1("hold_valid", out_valid, 1'b1);
      chk("hold_data", out_data, prev_data);
      chk1("hold_last", out_last, prev_last);
    end
    chk1("out_valid", out_valid, q_data.size() != 0);
    exp_rdy = !((m_slot == R - 1) && (q_data.size() != 0) && !r);
    chk1("in_ready", in_ready, exp_rdy);
    last_in_ready = in_ready;
    prev_hold = out_valid & ~r;
    prev_data = out_data;
    prev_last = out_last;
    if (out_valid && r && (q_data.size() != 0)) begin
      chk("out_data", out_data, q_data[0]);
      chk1("out_last", out_last, q_last[0]);
      last_taken_data = out_data;
      last_taken_last = out_last;
      if (sec_outs < 32) sec_last_mask[sec_outs] = out_last;
      sec_outs++;
      void'(q_data.pop_front());
      void'(q_last.pop_front());
    end
    last_accept = v & in_ready;
    if (last_accept) begin
      accepted++;
      m_lane[m_slot] = d;
      if (m_slot == R - 1) begin
        for (int i = 0; i < R; i++) pk[i*DW +: DW] = m_lane[i];
        lst = (cfg_length != 0) && (m_pkt >= int'(cfg_length) - 1);
        m_pkt = (lst || (cfg_length == 0)) ? 0 : m_pkt + 1;
        q_data.push_back(pk);
        q_last.push_back(lst);
        m_slot = 0;
      end else begin
        m_slot++;
      end
    end
  endtask

  task automatic send(input int n, input logic r);
    int target;
    int cyc;
    target = accepted + n;
    cyc = 0;
    while (accepted < target && cyc < 200) begin
      step(1'b1, word_ctr, r);
      if (last_accept) word_ctr++;
      cyc++;
    end
    chk("send_count", OW'(accepted), OW'(target));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_out_last", out_last, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk1("rst_in_ready", in_ready, 1'b1);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          r;
    logic          e_rdy;
    logic          e_ov;
    logic          e_last;
    logic          chk_d;
    logic [OW-1:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [DW-1:0] d, input logic r,
                              input logic e_rdy, input logic e_ov, input logic chk_d,
                              input logic [OW-1:0] e_data);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.e_rdy = e_rdy; t.e_ov = e_ov;
    t.e_last = 1'b0; t.chk_d = chk_d; t.e_data = e_data;
    return t;
  endfunction

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t tbl [18];
    logic [OW-1:0] p_w, a_w, b_w, m_w;
    int cyc;
    p_w = 128'h44444444_33333333_22222222_11111111;
    a_w = 128'hA0000003_A0000002_A0000001_A0000000;
    b_w = 128'hB0000003_B0000002_B0000001_B0000000;
    m_w = 128'hABCD0004_ABCD0003_ABCD0002_ABCD0001;
    // basic pack, then a stall on the completing word
    tbl[0]  = mk(1'b1, 32'h11111111, 1'b1, 1'b1, 1'b0, 1'b1, '0);
    tbl[1]  = mk(1'b1, 32'h22222222, 1'b1, 1'b1, 1'b0, 1'b1, '0);
    tbl[2]  = mk(1'b1, 32'h33333333, 1'b1, 1'b1, 1'b0, 1'b1, '0);
    tbl[3]  = mk(1'b1, 32'h44444444, 1'b1, 1'b1, 1'b0, 1'b1, '0);
    tbl[4]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, p_w);
    tbl[5]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, '0);
    tbl[6]  = mk(1'b1, 32'hA0000000, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    tbl[7]  = mk(1'b1, 32'hA0000001, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    tbl[8]  = mk(1'b1, 32'hA0000002, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    tbl[9]  = mk(1'b1, 32'hA0000003, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    tbl[10] = mk(1'b1, 32'hB0000000, 1'b0, 1'b1, 1'b1, 1'b1, a_w);
    tbl[11] = mk(1'b1, 32'hB0000001, 1'b0, 1'b1, 1'b1, 1'b1, a_w);
    tbl[12] = mk(1'b1, 32'hB0000002, 1'b0, 1'b1, 1'b1, 1'b1, a_w);
    tbl[13] = mk(1'b1, 32'hB0000003, 1'b0, 1'b0, 1'b1, 1'b1, a_w);
    tbl[14] = mk(1'b1, 32'hB0000003, 1'b1, 1'b1, 1'b1, 1'b1, a_w);
    tbl[15] = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, b_w);
    tbl[16] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, b_w);
    tbl[17] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, '0);

    do_reset();
    for (int i = 0; i < 18; i++) begin
      @(negedge aclk);
      in_valid = tbl[i].v;
      in_data = tbl[i].d;
      out_ready = tbl[i].r;
      cfg_length = '0;
      #1;
      chk1($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_rdy);
      chk1($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) chk1($sformatf("vec%0d_out_last", i), out_last, tbl[i].e_last);
      if (tbl[i].chk_d) chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].e_data);
    end

    // Backpressure: 7 words fit before the stall, the rest follow on release.
    cfg_drv = '0;
    do_reset();
    accepted = 0;
    sec_reset();
    send(7, 1'b0);
    repeat (3) begin
      step(1'b1, word_ctr, 1'b0);
      if (last_accept) word_ctr++;
    end
    chk1("bp_stall_in_ready", last_in_ready, 1'b0);
    chk("bp_accepted", OW'(accepted), OW'(7));
    send(5, 1'b1);
    idle(6);
    chk("bp_outputs", OW'(sec_outs), OW'(3));

    // Packet marking with cfg_length=3, then disabled.
    cfg_drv = 16'd3;
    do_reset();
    sec_reset();
    send(36, 1'b1);
    idle(6);
    chk("pkt_outputs", OW'(sec_outs), OW'(9));
    chk("pkt_last_mask", OW'(sec_last_mask[8:0]), OW'(9'b100100100));
    cfg_drv = '0;
    sec_reset();
    send(8, 1'b1);
    idle(6);
    chk("nolast_outputs", OW'(sec_outs), OW'(2));
    chk("nolast_mask", OW'(sec_last_mask), '0);

    // Mid-operation reset discards a partial group and restarts packet counting.
    cfg_drv = 16'd2;
    do_reset();
    send(4, 1'b1);
    idle(3);
    send(2, 1'b1);
    do_reset();
    sec_reset();
    word_ctr = 32'hABCD0001;
    send(4, 1'b1);
    idle(4);
    chk("mrst_outputs", OW'(sec_outs), OW'(1));
    chk("mrst_data", last_taken_data, m_w);
    chk1("mrst_last", last_taken_last, 1'b0);

    // Random soak against the scoreboard.
    cfg_drv = 16'd3;
    do_reset();
    accepted = 0;
    sec_reset();
    cyc = 0;
    while (accepted < 10000 && cyc < 60000) begin
      if ($urandom_range(0, 31) == 0) cfg_drv = LW'($urandom_range(1, 5));
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0);
      cyc++;
    end
    idle(8);
    chk("soak_accepted", OW'(accepted), OW'(10000));
    chk("soak_outputs", OW'(sec_outs), OW'(2500));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
